alu_div_ctrl: RTL and testbench

ALU_DIV_CTRL -- requirements
Module: alu_div_ctrl

---
 rtl/alu_pkg.sv | 18 +
 rtl/alu_div_ctrl.sv | 134 +++++++++++++
 tb/tb_alu_div_ctrl.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared ALU function codes and divide-controller state encoding.
package alu_pkg;

  localparam logic [5:0] FN_SRL  = 6'd2;
  localparam logic [5:0] FN_DIVU = 6'd27;
  localparam logic [5:0] FN_ADD  = 6'd32;
  localparam logic [5:0] FN_SUB  = 6'd34;
  localparam logic [5:0] FN_AND  = 6'd36;
  localparam logic [5:0] FN_OR   = 6'd37;
  localparam logic [5:0] FN_SLT  = 6'd42;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } div_state_t;

endpackage

// File: rtl/alu_div_ctrl.sv
// Unsigned restoring divider that borrows the shared EX-stage ALU for its
// trial subtractions and stalls the pipeline while it iterates.
//
// state | meaning
// IDLE  | ALU belongs to the pipeline; waiting for a DIVU start
// RUN   | one quotient bit per cycle, ALU performs R - D
// FIN   | done pulse; hi/lo already hold the result
module alu_div_ctrl
  import alu_pkg::*;
#(
  parameter int         WIDTH     = 32,
  parameter logic [5:0] DIVU_CODE = 6'd27
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       signal_in,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_cout,
  output logic             alu_own,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [5:0]       alu_signal,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_zero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] COUNT_LAST = CW'(WIDTH - 1);

  div_state_t       state, state_nxt;
  logic [WIDTH-1:0] r_reg, q_reg, d_reg;
  logic [WIDTH-1:0] r_nxt, q_nxt;
  logic [CW-1:0]    count;
  logic             accept;
  logic             sub_ok;

  // A reset in the same cycle wins over a DIVU start.
  assign accept = start && (signal_in == DIVU_CODE) && !rst;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next state, ALU mux ownership, handshake outputs and one iteration step.
  // R's MSB is the 33rd bit of the partial remainder: when it is set the
  // shifted value already exceeds D, so the wrapped ALU difference is correct.
  always_comb begin
    state_nxt  = state;
    alu_own    = 1'b0;
    alu_a      = '0;
    alu_b      = '0;
    alu_signal = signal_in;
    stall      = 1'b0;
    done       = 1'b0;
    sub_ok     = 1'b0;
    r_nxt      = r_reg;
    q_nxt      = q_reg;
    unique case (state)
      ST_IDLE: begin
        if (accept) begin
          stall     = 1'b1;
          state_nxt = (divisor == '0) ? ST_FIN : ST_RUN;
        end
      end
      ST_RUN: begin
        alu_own    = 1'b1;
        alu_signal = FN_SUB;
        stall      = 1'b1;
        alu_a      = {r_reg[WIDTH-2:0], q_reg[WIDTH-1]};
        alu_b      = d_reg;
        sub_ok     = r_reg[WIDTH-1] | alu_cout;
        r_nxt      = sub_ok ? alu_result : alu_a;
        q_nxt      = {q_reg[WIDTH-2:0], sub_ok};
        if (count == '0) state_nxt = ST_FIN;
      end
      ST_FIN: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Datapath registers: operand latch, iteration update and result capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_reg    <= '0;
      q_reg    <= '0;
      d_reg    <= '0;
      count    <= '0;
      hi       <= '0;
      lo       <= '0;
      div_zero <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (accept) begin
            if (divisor != '0) begin
              q_reg <= dividend;
              d_reg <= divisor;
              r_reg <= '0;
              count <= COUNT_LAST;
            end else begin
              lo       <= '1;
              hi       <= dividend;
              div_zero <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          r_reg <= r_nxt;
          q_reg <= q_nxt;
          if (count != '0) begin
            count <= count - 1'b1;
          end else begin
            hi       <= r_nxt;
            lo       <= q_nxt;
            div_zero <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_div_ctrl.sv
// Self-checking bench for alu_div_ctrl with a behavioural shared ALU and an
// arithmetic reference for quotient/remainder.
module tb_alu_div_ctrl;
  import alu_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic [5:0]   signal_in;
  logic         start;
  logic [W-1:0] dividend, divisor;
  logic [W-1:0] alu_result;
  logic         alu_cout;
  logic         alu_own;
  logic [W-1:0] alu_a, alu_b;
  logic [5:0]   alu_signal;
  logic         stall, done, div_zero;
  logic [W-1:0] hi, lo;

  int checks = 0;
  int errors = 0;

  alu_div_ctrl #(.WIDTH(W), .DIVU_CODE(FN_DIVU)) dut (
    .clk(clk), .rst(rst), .signal_in(signal_in), .start(start),
    .dividend(dividend), .divisor(divisor),
    .alu_result(alu_result), .alu_cout(alu_cout),
    .alu_own(alu_own), .alu_a(alu_a), .alu_b(alu_b), .alu_signal(alu_signal),
    .stall(stall), .done(done), .hi(hi), .lo(lo), .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  // Behavioural external ALU driven by the controller's operand mux.
  always_comb begin
    logic [W:0] sum;
    sum        = '0;
    alu_result = '0;
    alu_cout   = 1'b0;
    case (alu_signal)
      FN_SUB: begin
        sum = {1'b0, alu_a} + {1'b0, ~alu_b} + {{W{1'b0}}, 1'b1};
        alu_result = sum[W-1:0];
        alu_cout   = sum[W];
      end
      FN_ADD: begin
        sum = {1'b0, alu_a} + {1'b0, alu_b};
        alu_result = sum[W-1:0];
        alu_cout   = sum[W];
      end
      FN_AND:  alu_result = alu_a & alu_b;
      FN_OR:   alu_result = alu_a | alu_b;
      default: alu_result = '0;
    endcase
  end

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One DIVU transaction; add_at>0 presents an ADD start in cycle N+add_at.
  task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b, input int add_at);
    logic [W-1:0] exp_lo, exp_hi;
    logic         exp_dz;
    int           exp_lat;
    int           k;
    bit           got, seen_own;
    got = 0;
    seen_own = 0;
    if (b == 0) begin
      exp_lo = '1; exp_hi = a; exp_dz = 1'b1; exp_lat = 1;
    end else begin
      exp_lo = a / b; exp_hi = a % b; exp_dz = 1'b0; exp_lat = W + 1;
    end
    @(posedge clk); #1;
    start = 1'b1; signal_in = FN_DIVU; dividend = a; divisor = b;
    @(negedge clk);
    chk("accept_stall", {31'b0, stall}, 1);
    chk("accept_own", {31'b0, alu_own}, 0);
    @(posedge clk); #1;
    start = (add_at == 1); signal_in = FN_ADD;
    dividend = $urandom; divisor = $urandom;
    k = 1;
    while (k <= W + 5) begin
      @(negedge clk);
      if (done) begin got = 1; break; end
      if (alu_own) seen_own = 1;
      chk("run_stall", {31'b0, stall}, 1);
      chk("run_signal", {26'b0, alu_signal}, {26'b0, FN_SUB});
      @(posedge clk); #1;
      start = (k + 1 == add_at);
      k++;
    end
    chk("done_seen", {31'b0, got}, 1);
    chk("latency", k, exp_lat);
    chk("lo", lo, exp_lo);
    chk("hi", hi, exp_hi);
    chk("div_zero", {31'b0, div_zero}, {31'b0, exp_dz});
    chk("fin_stall", {31'b0, stall}, 0);
    chk("fin_own", {31'b0, alu_own}, 0);
    chk("own_used", {31'b0, seen_own}, {31'b0, (b != 0)});
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("done_pulse_end", {31'b0, done}, 0);
    chk("lo_hold", lo, exp_lo);
    chk("hi_hold", hi, exp_hi);
  endtask

  initial begin
    int seen_done;
    logic [W-1:0] ra, rb;
    rst = 1'b1; start = 1'b0; signal_in = 6'd0; dividend = '0; divisor = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    chk("rst_done", {31'b0, done}, 0);
    chk("rst_dz", {31'b0, div_zero}, 0);
    chk("rst_stall", {31'b0, stall}, 0);
    chk("rst_own", {31'b0, alu_own}, 0);
    @(posedge clk); #1 rst = 1'b0;

    run_div(32'd100, 32'd7, 0);
    run_div(32'hFFFF_FFFF, 32'd1, 0);
    run_div(32'd3, 32'd10, 0);
    run_div(32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_div(32'hFFFF_FFFF, 32'h8000_0000, 0);
    run_div(32'd5, 32'd0, 0);
    run_div(32'd50, 32'd6, 5);

    // Non-divide function code passes straight through.
    @(posedge clk); #1;
    start = 1'b1; signal_in = FN_AND; dividend = 32'd77; divisor = 32'd3;
    @(negedge clk);
    chk("and_signal", {26'b0, alu_signal}, {26'b0, FN_AND});
    chk("and_own", {31'b0, alu_own}, 0);
    chk("and_stall", {31'b0, stall}, 0);
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    chk("and_no_run", {31'b0, alu_own}, 0);
    chk("and_no_done", {31'b0, done}, 0);

    // Reset partway through a divide aborts it.
    @(posedge clk); #1;
    start = 1'b1; signal_in = FN_DIVU; dividend = 32'd100; divisor = 32'd7;
    @(posedge clk); #1 start = 1'b0;
    repeat (9) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("abort_own", {31'b0, alu_own}, 0);
    chk("abort_stall", {31'b0, stall}, 0);
    chk("abort_hi", hi, 0);
    chk("abort_lo", lo, 0);
    seen_done = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) seen_done++;
    end
    chk("abort_no_done", seen_done, 0);
    run_div(32'd9, 32'd4, 0);

    // Reset beats a simultaneous start.
    @(posedge clk); #1;
    rst = 1'b1; start = 1'b1; signal_in = FN_DIVU; dividend = 32'd100; divisor = 32'd7;
    @(negedge clk);
    chk("rst_pri_stall", {31'b0, stall}, 0);
    @(posedge clk); #1 rst = 1'b0; start = 1'b0;
    @(negedge clk);
    chk("rst_pri_own", {31'b0, alu_own}, 0);
    chk("rst_pri_done", {31'b0, done}, 0);
    chk("rst_pri_lo", lo, 0);

    for (int i = 0; i < 20; i++) begin
      ra = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = '0;
        1:       rb = $urandom_range(1, 15);
        2:       rb = $urandom >> $urandom_range(0, 31);
        default: rb = $urandom;
      endcase
      if (rb == 0 && ($urandom_range(0, 1) == 1)) rb = 32'd1;
      run_div(ra, rb, $urandom_range(0, 1) == 1 ? $urandom_range(2, 30) : 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
